// File: rtl/dcache_req_arbiter.sv
// dcache_req_arbiter: round-robin sharing of one HPDC request port with AMO serialisation, fence drain and response routing
package dcache_req_arbiter_pkg;
   // Opcode encoding: LOAD, STORE, then the AMO group LR..MAXU occupies one contiguous range
   localparam logic [3:0] OP_LOAD = 4'd0;
   localparam logic [3:0] OP_LR   = 4'd2;
   localparam logic [3:0] OP_ADD  = 4'd5;
   localparam logic [3:0] OP_MAXU = 4'd12;
   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  sid;
      logic [3:0]  tid;
   } hpdcache_req_t;
   typedef struct packed {
      logic [31:0] rdata;
      logic [3:0]  sid;
      logic [3:0]  tid;
      logic        error;
   } hpdcache_rsp_t;
   function automatic logic is_amo(input logic [3:0] op);
      return (op >= OP_LR) && (op <= OP_MAXU);
   endfunction
endpackage

module dcache_req_arbiter
   import dcache_req_arbiter_pkg::*;
#(
   parameter int NUM_REQ         = 3,
   parameter int MAX_OUTSTANDING = 4,
   parameter int SID_BASE        = 1
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic [NUM_REQ-1:0]   req_valid_i,
   input  hpdcache_req_t        req_i [NUM_REQ],
   output logic [NUM_REQ-1:0]   req_ready_o,
   output logic                 dcache_req_valid_o,
   output hpdcache_req_t        dcache_req_o,
   input  logic                 dcache_ready_i,
   input  logic                 dcache_rsp_valid_i,
   input  hpdcache_rsp_t        dcache_rsp_i,
   output logic [NUM_REQ-1:0]   rsp_valid_o,
   output hpdcache_rsp_t        rsp_o,
   input  logic                 fence_i,
   input  logic                 wbuf_empty_i,
   output logic                 fence_done_o,
   output logic                 rsp_err_o
);
   localparam int IW = $clog2(NUM_REQ);
   localparam logic [1:0] ARB        = 2'd0;
   localparam logic [1:0] AMO_WAIT   = 2'd1;
   localparam logic [1:0] FENCE_WAIT = 2'd2;
   localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);
   localparam logic [3:0] SID_LO  = 4'(SID_BASE);
   localparam logic [3:0] SID_HI  = 4'(SID_BASE + NUM_REQ);

   logic [1:0]         state, st;
   logic [IW-1:0]      rr_ptr, ptr, win, win_lo, win_hi, amo_idx, rsp_idx;
   logic [3:0]         cnt [NUM_REQ];
   logic [3:0]         amo_tid;
   logic [NUM_REQ-1:0] elig;
   logic               hi_hit, hs, rsp_hit, amo_done, zero_hit, idle, fence_pend;

   // While reset is held, combinational outputs see the reset state rather than stale registers
   assign st  = rstn_i ? state : ARB;
   assign ptr = rstn_i ? rr_ptr : '0;

   // Round-robin pick: lowest eligible index at or above the pointer, else lowest eligible overall
   always_comb begin
      elig   = '0;
      win_lo = '0;
      win_hi = '0;
      hi_hit = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         elig[i] = req_valid_i[i] && (!rstn_i || (cnt[i] < MAX_CNT));
         if (elig[i]) begin
            win_lo = IW'(i);
            if (IW'(i) >= ptr) begin
               win_hi = IW'(i);
               hi_hit = 1'b1;
            end
         end
      end
   end

   assign win                = hi_hit ? win_hi : win_lo;
   assign dcache_req_valid_o = (st == ARB) && (|elig);
   assign hs                 = dcache_req_valid_o && dcache_ready_i;
   assign rsp_o              = dcache_rsp_i;
   assign rsp_hit            = dcache_rsp_valid_i && (dcache_rsp_i.sid >= SID_LO) && (dcache_rsp_i.sid < SID_HI);
   assign rsp_idx            = IW'(dcache_rsp_i.sid - SID_LO);
   assign amo_done           = (state == AMO_WAIT) && rsp_hit && (rsp_idx == amo_idx) && (dcache_rsp_i.tid == amo_tid);
   assign fence_done_o       = (st == FENCE_WAIT) && idle && wbuf_empty_i;

   // Winner payload with its sid rewritten, per-requester accept and response routing, drain status
   always_comb begin
      dcache_req_o     = req_i[win];
      dcache_req_o.sid = SID_LO + 4'(win);
      req_ready_o      = '0;
      rsp_valid_o      = '0;
      zero_hit         = 1'b0;
      idle             = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready_o[i] = hs && (win == IW'(i));
         rsp_valid_o[i] = rsp_hit && (rsp_idx == IW'(i));
         zero_hit       = zero_hit || (rsp_valid_o[i] && (cnt[i] == 4'd0));
         idle           = idle && (cnt[i] == 4'd0);
      end
   end

   // Outstanding counters (issue and response in one cycle cancel), sticky error, round-robin pointer
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
         rr_ptr    <= '0;
         rsp_err_o <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready_o[i] && !rsp_valid_o[i]) cnt[i] <= cnt[i] + 4'd1;
            else if (!req_ready_o[i] && rsp_valid_o[i] && (cnt[i] != 4'd0)) cnt[i] <= cnt[i] - 4'd1;
         end
         if (dcache_rsp_valid_i && (!rsp_hit || zero_hit)) rsp_err_o <= 1'b1;
         if (hs) rr_ptr <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end
   end

   // Mode control: an AMO blocks issue until its own response; a fence blocks issue until drained
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state      <= ARB;
         fence_pend <= 1'b0;
         amo_idx    <= '0;
         amo_tid    <= '0;
      end else if (state == ARB) begin
         if (hs && is_amo(dcache_req_o.op)) begin
            state      <= AMO_WAIT;
            amo_idx    <= win;
            amo_tid    <= dcache_req_o.tid;
            fence_pend <= fence_i;
         end else if (fence_i) begin
            state <= FENCE_WAIT;
         end
      end else if (state == AMO_WAIT) begin
         if (fence_i) fence_pend <= 1'b1;
         if (amo_done) begin
            state      <= (fence_pend || fence_i) ? FENCE_WAIT : ARB;
            fence_pend <= 1'b0;
         end
      end else if (fence_done_o) begin
         state <= ARB;
      end
   end
endmodule

// File: tb/tb_dcache_req_arbiter.sv
// tb_dcache_req_arbiter: directed stimulus with a cycle-level reference model and literal spot checks
module tb_dcache_req_arbiter;
   import dcache_req_arbiter_pkg::*;
   localparam int N = 3;

   logic          clk = 1'b0;
   logic          rstn_i, dcache_ready_i, dcache_rsp_valid_i, fence_i, wbuf_empty_i;
   logic [N-1:0]  req_valid_i, req_ready_o, rsp_valid_o;
   hpdcache_req_t req_i [N];
   hpdcache_req_t dcache_req_o, xreq;
   hpdcache_rsp_t dcache_rsp_i, rsp_o;
   logic          dcache_req_valid_o, fence_done_o, rsp_err_o;

   dcache_req_arbiter dut (
      .clk_i(clk), .rstn_i(rstn_i), .req_valid_i(req_valid_i), .req_i(req_i),
      .req_ready_o(req_ready_o), .dcache_req_valid_o(dcache_req_valid_o), .dcache_req_o(dcache_req_o),
      .dcache_ready_i(dcache_ready_i), .dcache_rsp_valid_i(dcache_rsp_valid_i), .dcache_rsp_i(dcache_rsp_i),
      .rsp_valid_o(rsp_valid_o), .rsp_o(rsp_o), .fence_i(fence_i), .wbuf_empty_i(wbuf_empty_i),
      .fence_done_o(fence_done_o), .rsp_err_o(rsp_err_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   // Reference model: per-requester in-flight counts, rotating priority start, busy flags
   int mc [N] = '{0, 0, 0};
   int mptr = 0, amo_who = 0, amo_t = 0;
   bit merr = 0, amo_busy = 0, fence_busy = 0, fence_pend = 0;
   int c [N];
   int p, w, j, idx;
   bit ev, hs, rv, edone, ba, bf;

   always @(negedge clk) begin
      for (int i = 0; i < N; i++) c[i] = rstn_i ? mc[i] : 0;
      p  = rstn_i ? mptr : 0;
      ba = rstn_i && amo_busy;
      bf = rstn_i && fence_busy;
      w  = -1;
      for (int k = 0; k < N; k++) begin
         idx = (p + k) % N;
         if (w < 0 && req_valid_i[idx] && c[idx] < 4) w = idx;
      end
      ev    = !ba && !bf && (w >= 0);
      hs    = ev && dcache_ready_i;
      j     = int'(dcache_rsp_i.sid) - 1;
      rv    = dcache_rsp_valid_i && (j >= 0) && (j < N);
      edone = bf && (c[0] == 0) && (c[1] == 0) && (c[2] == 0) && wbuf_empty_i;
      chk("m_req_valid", dcache_req_valid_o, ev);
      if (ev) begin
         xreq     = req_i[w];
         xreq.sid = 4'(w + 1);
         chk("m_req", dcache_req_o, xreq);
      end
      chk("m_req_ready", req_ready_o, hs ? 3'(1 << w) : 3'b000);
      chk("m_rsp_valid", rsp_valid_o, rv ? 3'(1 << j) : 3'b000);
      chk("m_rsp", rsp_o, dcache_rsp_i);
      chk("m_fence_done", fence_done_o, edone);
      chk("m_rsp_err", rsp_err_o, merr);
      if (!rstn_i) begin
         for (int i = 0; i < N; i++) mc[i] = 0;
         mptr = 0; merr = 0; amo_busy = 0; fence_busy = 0; fence_pend = 0;
      end else begin
         if (dcache_rsp_valid_i && !rv) merr = 1;
         else if (rv && c[j] == 0) merr = 1;
         for (int i = 0; i < N; i++) begin
            if ((hs && w == i) && !(rv && j == i)) mc[i]++;
            else if (!(hs && w == i) && (rv && j == i) && mc[i] > 0) mc[i]--;
         end
         if (hs) mptr = (w + 1) % N;
         if (amo_busy) begin
            if (fence_i) fence_pend = 1;
            if (rv && j == amo_who && dcache_rsp_i.tid == 4'(amo_t)) begin
               amo_busy = 0; fence_busy = fence_pend; fence_pend = 0;
            end
         end else if (fence_busy) begin
            if (edone) fence_busy = 0;
         end else if (hs && (req_i[w].op inside {[OP_LR:OP_MAXU]})) begin
            amo_busy = 1; amo_who = w; amo_t = int'(req_i[w].tid); fence_pend = fence_i;
         end else if (fence_i) begin
            fence_busy = 1;
         end
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic rsp(input int sid, input int tid);
      dcache_rsp_valid_i = 1'b1;
      dcache_rsp_i.sid   = 4'(sid);
      dcache_rsp_i.tid   = 4'(tid);
      dcache_rsp_i.rdata = 32'hA000 + 32'(sid);
   endtask

   task automatic drain(input int sid, input int n);
      req_valid_i = '0;
      for (int k = 0; k < n; k++) begin
         rsp(sid, 0);
         nxt();
      end
      dcache_rsp_valid_i = 1'b0;
   endtask

   logic [2:0] rr_exp  [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
   logic [3:0] sid_exp [6] = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3};

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      rstn_i = 1'b0; dcache_ready_i = 1'b1; dcache_rsp_valid_i = 1'b0; fence_i = 1'b0;
      wbuf_empty_i = 1'b1; req_valid_i = '0; dcache_rsp_i = '0;
      for (int i = 0; i < N; i++) begin
         req_i[i].op    = OP_LOAD;
         req_i[i].addr  = 32'h1000 * 32'(i + 1);
         req_i[i].wdata = 32'h55 + 32'(i);
         req_i[i].sid   = 4'hF;
         req_i[i].tid   = 4'(i);
      end
      smp();
      chk("rst_valid", dcache_req_valid_o, 1'b0);
      chk("rst_err", rsp_err_o, 1'b0);
      chk("rst_done", fence_done_o, 1'b0);
      nxt();
      rstn_i = 1'b1;
      nxt();
      // round-robin
      req_valid_i = 3'b111;
      for (int k = 0; k < 6; k++) begin
         smp();
         chk("rr_ready", req_ready_o, rr_exp[k]);
         chk("rr_sid", dcache_req_o.sid, sid_exp[k]);
         nxt();
      end
      req_valid_i = '0;
      for (int k = 0; k < 6; k++) begin
         rsp(k % 3 + 1, 0);
         smp();
         chk("rr_rsp_route", rsp_valid_o, rr_exp[k]);
         nxt();
      end
      dcache_rsp_valid_i = 1'b0;
      // outstanding limit
      req_valid_i = 3'b011;
      for (int k = 0; k < 8; k++) begin
         smp();
         if (k == 6) chk("lim_4th_load", req_ready_o, 3'b001);
         if (k == 7) chk("lim_skip_to_1", req_ready_o, 3'b010);
         nxt();
      end
      rsp(1, 0);
      smp();
      chk("lim_all_full", dcache_req_valid_o, 1'b0);
      chk("lim_rsp_route", rsp_valid_o, 3'b001);
      nxt();
      dcache_rsp_valid_i = 1'b0;
      smp();
      chk("lim_reenable", req_ready_o, 3'b001);
      nxt();
      drain(1, 4);
      drain(2, 4);
      // AMO wait
      req_i[2].op  = OP_ADD;
      req_i[2].tid = 4'd5;
      req_valid_i  = 3'b100;
      smp();
      chk("amo_grant", req_ready_o, 3'b100);
      nxt();
      req_valid_i = 3'b111;
      for (int k = 0; k < 3; k++) begin
         smp();
         chk("amo_block", dcache_req_valid_o, 1'b0);
         nxt();
      end
      rsp(3, 5);
      smp();
      chk("amo_block_rsp", dcache_req_valid_o, 1'b0);
      nxt();
      dcache_rsp_valid_i = 1'b0;
      smp();
      chk("amo_resume", req_ready_o, 3'b001);
      nxt();
      req_i[2].op  = OP_LOAD;
      req_i[2].tid = 4'd2;
      drain(1, 1);
      // fence
      req_valid_i = 3'b011;
      smp();
      chk("f_pre1", req_ready_o, 3'b010);
      nxt();
      smp();
      chk("f_pre2", req_ready_o, 3'b001);
      nxt();
      req_valid_i  = '0;
      fence_i      = 1'b1;
      wbuf_empty_i = 1'b0;
      nxt();
      fence_i     = 1'b0;
      req_valid_i = 3'b111;
      for (int k = 0; k < 2; k++) begin
         smp();
         chk("f_block", dcache_req_valid_o, 1'b0);
         chk("f_not_done", fence_done_o, 1'b0);
         nxt();
      end
      rsp(1, 0);
      smp();
      chk("f_not_done_r1", fence_done_o, 1'b0);
      nxt();
      wbuf_empty_i = 1'b1;
      rsp(2, 0);
      smp();
      chk("f_not_done_r2", fence_done_o, 1'b0);
      nxt();
      dcache_rsp_valid_i = 1'b0;
      smp();
      chk("f_done", fence_done_o, 1'b1);
      chk("f_done_block", dcache_req_valid_o, 1'b0);
      nxt();
      smp();
      chk("f_done_once", fence_done_o, 1'b0);
      chk("f_resume", req_ready_o, 3'b010);
      nxt();
      drain(2, 1);
      // errors and simultaneous events
      rsp(7, 0);
      smp();
      chk("err_rsp_valid", rsp_valid_o, 3'b000);
      nxt();
      dcache_rsp_valid_i = 1'b0;
      smp();
      chk("err_sticky", rsp_err_o, 1'b1);
      nxt();
      req_valid_i = 3'b001;
      smp();
      chk("sim_first", req_ready_o, 3'b001);
      nxt();
      rsp(1, 0);
      smp();
      chk("sim_ready", req_ready_o, 3'b001);
      chk("sim_rsp", rsp_valid_o, 3'b001);
      nxt();
      dcache_rsp_valid_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         smp();
         chk("sim_fill", req_ready_o, 3'b001);
         nxt();
      end
      smp();
      chk("sim_full", req_ready_o, 3'b000);
      nxt();
      rstn_i = 1'b0;
      smp();
      chk("rst_err_held", rsp_err_o, 1'b1);
      nxt();
      rstn_i      = 1'b1;
      req_valid_i = '0;
      smp();
      chk("rst_err_clr", rsp_err_o, 1'b0);
      nxt();
      rsp(2, 0);
      smp();
      chk("post_rst_rsp", rsp_valid_o, 3'b010);
      nxt();
      dcache_rsp_valid_i = 1'b0;
      req_valid_i        = 3'b001;
      smp();
      chk("post_rst_err", rsp_err_o, 1'b1);
      chk("post_rst_grant", req_ready_o, 3'b001);
      nxt();
      req_valid_i = '0;
      nxt();
      nxt();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
